// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_size_t  - request size encoding (byte / half / word / illegal)
//   lsu_state_t - load_store_unit FSM states
//   LANE_MASK_* - byte-lane masks for each access size at offset 0
//   lane_bits() - expands a size/offset pair into a 32-bit lane bit-mask
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } lsu_size_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } lsu_state_t;

  localparam logic [3:0] LANE_MASK_BYTE = 4'b0001;
  localparam logic [3:0] LANE_MASK_HALF = 4'b0011;
  localparam logic [3:0] LANE_MASK_WORD = 4'b1111;

  // Bits of the 32-bit word touched by an access of 'size' at byte offset 'off'.
  function automatic logic [31:0] lane_bits(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    logic [31:0] bits;
    case (size)
      SZ_BYTE: m = LANE_MASK_BYTE;
      SZ_HALF: m = LANE_MASK_HALF;
      default: m = LANE_MASK_WORD;
    endcase
    m = m << off;
    for (int i = 0; i < 4; i++) begin
      bits[8*i +: 8] = {8{m[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane steering for sub-word accesses.
// Little-endian: byte k of a word is bits [8k+7:8k].
// Ports:
//   off       in  2   byte offset within the word (addr[1:0])
//   size      in  2   access size (lsu_size_t encoding)
//   is_signed in  1   sign-extend byte/half loads
//   rd_word   in  32  word read from memory (load path)
//   load_data out 32  extracted and extended load result
//   old_word  in  32  word previously read for read-modify-write
//   new_data  in  32  store data; low byte/half used for sub-word stores
//   merged    out 32  old_word with the target lane(s) replaced
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] rd_word,
  output logic [31:0] load_data,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] merged
);

  logic [31:0] shifted;
  logic [31:0] repl;
  logic [31:0] lanes;

  always_comb begin
    shifted = rd_word >> {off, 3'b000};
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Replicating the store data across every lane means the lane mask alone
  // selects where it lands, with no separate shifter.
  always_comb begin
    case (size)
      SZ_BYTE: repl = {4{new_data[7:0]}};
      SZ_HALF: repl = {2{new_data[15:0]}};
      default: repl = new_data;
    endcase
    lanes  = lane_bits(size, off);
    merged = (old_word & ~lanes) | (repl & lanes);
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: converts byte-addressed load/store requests into word
// accesses on a combinational-read, clocked-write data memory.
// Optional feature macro: LSU_SUBWORD_EN (byte/half accesses, read-modify-write).
// Without it only word accesses are legal; byte/half return an error.
// Handshake: a request is accepted on a rising edge with req_valid && req_ready;
// req_* must stay stable until then. req_ready is high only in IDLE. The
// response is a one-cycle resp_valid pulse with no backpressure.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            request handshake
//   req_we, req_size, req_signed   store flag, size, load sign-extension
//   req_addr, req_wdata            byte address, store data
//   resp_valid, resp_rdata, resp_err  completion pulse, load data, error flag
//   mem_we, mem_addr, mem_wd       data memory write enable, word index, write data
//   mem_rd                         data memory combinational read data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  lsu_state_t  state_q, state_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_word;

`ifdef LSU_SUBWORD_EN
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] merge_q;
  logic [31:0] merged;

  lsu_lane_align u_align (
    .off       (addr_q[1:0]),
    .size      (size_q),
    .is_signed (signed_q),
    .rd_word   (mem_rd),
    .load_data (load_data),
    .old_word  (merge_q),
    .new_data  (wdata_q),
    .merged    (merged)
  );

  assign store_word = (size_q == SZ_WORD) ? wdata_q : merged;
`else
  assign load_data  = mem_rd;
  assign store_word = wdata_q;
`endif

  assign accept   = req_valid && req_ready;
  assign mem_addr = {2'b00, addr_q[31:2]};

  // Checks run on the request fields at the accept edge; the handshake keeps
  // them stable, so they equal the latched copy and the error path can reach
  // DONE one cycle after acceptance.
  always_comb begin
    req_err = 1'b0;
    if (req_size == SZ_ILL) begin
      req_err = 1'b1;
`ifndef LSU_SUBWORD_EN
    end else if (req_size != SZ_WORD) begin
      req_err = 1'b1;
`endif
    end else if ((req_size == SZ_HALF && req_addr[0]) ||
                 (req_size == SZ_WORD && req_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end else if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) begin
      req_err = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                 state_d = ST_DONE;
          else if (!req_we)            state_d = ST_LOAD;
          else if (req_size == SZ_WORD) state_d = ST_WRITE;
`ifdef LSU_SUBWORD_EN
          else                         state_d = ST_READ;
`else
          else                         state_d = ST_DONE;
`endif
        end
      end
      ST_LOAD:  state_d = ST_DONE;
`ifdef LSU_SUBWORD_EN
      ST_READ:  state_d = ST_WRITE;
`endif
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_DONE);
    mem_we     = (state_q == ST_WRITE);
    mem_wd     = (state_q == ST_WRITE) ? store_word : 32'h0;
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Request latch and result registers. Results are written only on the
  // transition into DONE so they hold until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept && req_err) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
          end
        end
        ST_LOAD: begin
          rdata_q <= we_q ? 32'h0 : load_data;
          err_q   <= 1'b0;
        end
        ST_WRITE: begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_SUBWORD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q   <= SZ_WORD;
      signed_q <= 1'b0;
      merge_q  <= 32'h0;
    end else begin
      if (accept) begin
        size_q   <= req_size;
        signed_q <= req_signed;
      end
      if (state_q == ST_READ) merge_q <= mem_rd;
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit
// against a word-array reference model, with a behavioural data_mem.
module tb_load_store_unit;

  localparam int MEM_WORDS = 128;
`ifdef LSU_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // Clock
  always #5 clk = ~clk;

  // data_mem fixture: combinational read, write on posedge
  logic [31:0] mem [0:MEM_WORDS-1];
  assign mem_rd = (mem_addr < 32'(MEM_WORDS)) ? mem[mem_addr[6:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_we && mem_addr < 32'(MEM_WORDS)) mem[mem_addr[6:0]] <= mem_wd;
  end

  // Reference model state
  logic [31:0] ref_mem [0:7];
  logic [31:0] last_rdata;
  logic        last_err;
  logic [31:0] got_rdata;
  logic        got_err;
  logic [31:0] got_wd;
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
    if (!SUBWORD && size != 2'd2) return 1'b1;
    if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
    if ((addr / 4) >= MEM_WORDS) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input int off,
                                             input logic [1:0] size, input bit sgn);
    logic [31:0] v;
    v = w >> (8 * off);
    if (size == 2'd0) begin
      v = v % 256;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (size == 2'd1) begin
      v = v % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return w;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                              input int off, input logic [1:0] size);
    logic [31:0] mask;
    if (size == 2'd2) return wd;
    mask = (size == 2'd0) ? 32'hFF : 32'hFFFF;
    return (old & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
  endfunction

  // Driver: issue one request, follow it to its response and check it.
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bit          e_err;
    int          idx;
    int          off;
    int          e_lat;
    int          e_pulses;
    logic [31:0] e_rdata;
    logic [31:0] e_wd;
    int          lat;
    int          pulses;

    idx      = int'(addr / 4);
    off      = int'(addr % 4);
    e_err    = model_err(size, addr);
    e_rdata  = 32'h0;
    e_wd     = 32'h0;
    e_pulses = 0;
    if (e_err)              e_lat = 1;
    else if (!we)           e_lat = 2;
    else if (size == 2'd2)  e_lat = 2;
    else                    e_lat = 3;
    if (!e_err && !we) e_rdata = model_load(ref_mem[idx], off, size, sgn);
    if (!e_err && we) begin
      e_wd     = model_store(ref_mem[idx], wdata, off, size);
      e_pulses = 1;
    end

    @(negedge clk);
    check("hold_rdata", resp_rdata, last_rdata);
    check("hold_err", 32'(resp_err), 32'(last_err));
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;

    lat    = 0;
    pulses = 0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_we) begin
        pulses++;
        got_wd = mem_wd;
      end
      if (resp_valid) begin
        lat       = c;
        got_rdata = resp_rdata;
        got_err   = resp_err;
      end else begin
        check("busy_ready", 32'(req_ready), 32'd0);
      end
    end
    check("latency", 32'(lat), 32'(e_lat));
    check("resp_rdata", got_rdata, e_rdata);
    check("resp_err", 32'(got_err), 32'(e_err));
    check("we_pulses", 32'(pulses), 32'(e_pulses));
    if (e_pulses != 0) begin
      check("mem_wd", got_wd, e_wd);
      ref_mem[idx] = e_wd;
    end
    if (idx < 8) check("mem_word", mem[idx], ref_mem[idx]);
    last_rdata = e_rdata;
    last_err   = e_err;
  endtask

  initial begin
    int          idx;
    logic [31:0] addr;

    n_checks   = 0;
    n_fail     = 0;
    last_rdata = 32'h0;
    last_err   = 1'b0;
    got_rdata  = 32'h0;
    got_err    = 1'b0;
    got_wd     = 32'h0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < 8; i++) ref_mem[i] = 32'h0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    rst_n = 1'b1;

    // Preload words 0..7 with word stores; word 1 gets the reference pattern
    for (int i = 0; i < 8; i++) begin
      run_req(1'b1, 2'd2, 1'b0, 32'(i * 4), (i == 1) ? 32'h8081_8283 : $urandom);
    end

`ifdef LSU_SUBWORD_EN
    run_req(1'b0, 2'd0, 1'b1, 32'h5, 32'h0);
    check("lb_signed", got_rdata, 32'hFFFF_FF82);
    run_req(1'b0, 2'd0, 1'b0, 32'h5, 32'h0);
    check("lb_unsigned", got_rdata, 32'h0000_0082);
    run_req(1'b0, 2'd1, 1'b1, 32'h6, 32'h0);
    check("lh_signed", got_rdata, 32'hFFFF_8081);
    run_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    check("lw", got_rdata, 32'h8081_8283);
    run_req(1'b1, 2'd0, 1'b0, 32'h7, 32'h0000_00AB);
    check("sb_wd", got_wd, 32'hAB81_8283);
    run_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    check("sb_readback", got_rdata, 32'hAB81_8283);
    run_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h8081_8283);
`else
    run_req(1'b0, 2'd0, 1'b0, 32'h4, 32'h0);
    check("lb_disabled_err", 32'(got_err), 32'd1);
    run_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    check("lw", got_rdata, 32'h8081_8283);
`endif

    // Error cases: no write, memory unchanged
    run_req(1'b1, 2'd2, 1'b0, 32'h6, 32'hDEAD_BEEF);
    run_req(1'b0, 2'd1, 1'b0, 32'h5, 32'h0);
    run_req(1'b1, 2'd3, 1'b0, 32'h4, 32'hDEAD_BEEF);
    run_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    check("err_flag_range", 32'(got_err), 32'd1);
    for (int i = 0; i < 8; i++) check("mem_after_err", mem[i], ref_mem[i]);

    // Reset in the first busy cycle of a store drops it entirely
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = SUBWORD ? 2'd0 : 2'd2;
    req_signed = 1'b0;
    req_addr   = SUBWORD ? 32'h7 : 32'h4;
    req_wdata  = SUBWORD ? 32'h0000_00AB : 32'h1234_5678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_we", 32'(mem_we), 32'd0);
    check("rst_mid_resp", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_resp", 32'(resp_valid), 32'd0);
      check("post_rst_ready", 32'(req_ready), 32'd1);
      check("post_rst_we", 32'(mem_we), 32'd0);
    end
    check("rst_mid_word1", mem[1], 32'h8081_8283);
    last_rdata = 32'h0;
    last_err   = 1'b0;

    // Randomized traffic over words 0..7 plus a few out-of-range indices
    for (int n = 0; n < 120; n++) begin
      idx = int'($urandom_range(0, 9));
      if (idx >= 8) idx = 128 + (idx - 8) * int'($urandom_range(1, 50));
      addr = 32'(idx * 4 + int'($urandom_range(0, 3)));
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), addr, $urandom);
    end
    for (int i = 0; i < 8; i++) check("mem_final", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
